// File: rtl/uart_port_arbiter_pkg.sv
// Shared types and sizing helpers for the uart register-port arbiter.
package uart_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Requester index width; a single bit is kept even for tiny NUM_REQ.
    function automatic int ptr_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Timeout counter width; must hold TIMEOUT_CYCLES-1.
    function automatic int cnt_w(input int timeout_cycles);
        return (timeout_cycles <= 2) ? 1 : $clog2(timeout_cycles);
    endfunction

endpackage

// File: rtl/uart_port_arbiter_if.sv
// Requester-side and uart-side bus of the uart port arbiter.
// Handshake: req_i is held until gnt_o pulses (accept); each accepted request yields exactly one
// rvalid_o pulse (err_o qualifies it); uart_rreq_o/uart_wreq_o are levels held until the matching ack.
interface uart_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [NUM_REQ-1:0]            err_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic [ADDR_WIDTH-1:0]         uart_addr_o;
    logic [DATA_WIDTH-1:0]         uart_wdata_o;
    logic                          uart_rreq_o;
    logic                          uart_wreq_o;
    logic                          uart_rack_i;
    logic                          uart_wack_i;
    logic [DATA_WIDTH-1:0]         uart_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, uart_rack_i, uart_wack_i, uart_rdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o, uart_addr_o, uart_wdata_o, uart_rreq_o, uart_wreq_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, uart_rack_i, uart_wack_i, uart_rdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o, uart_addr_o, uart_wdata_o, uart_rreq_o, uart_wreq_o
    );

endinterface

// File: rtl/uart_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from i_ptr+1, wrapping.
module uart_port_arbiter_rr_arbiter
    import uart_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = PTR_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one uart register port among NUM_REQ requesters: round-robin, one transaction in flight,
// per-transaction timeout so a silent uart cannot lock the port.
module uart_port_arbiter
    import uart_port_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ        = 2,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_port_arbiter_if.slave  bus,
    output logic                busy_o
);

    localparam int PTR_W = ptr_w(NUM_REQ);
    localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [NUM_REQ-1:0]    r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [PTR_W-1:0]      w_arb_idx;
    logic                  w_arb_any;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_start;
    logic                  w_match;
    logic                  w_timeout;
    logic                  w_done;

    uart_port_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req (bus.req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Grant is suppressed while reset is asserted so no requester sees an accept that is then lost.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_start     = 1'b0;
        w_match     = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_any && !rst_i) begin
                    w_gnt       = w_arb_gnt;
                    w_start     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_match     = r_we ? bus.uart_wack_i : bus.uart_rack_i;
                w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST) && !w_match;
                w_done      = w_match || w_timeout;
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_ptr    <= PTR_W'(NUM_REQ - 1);
            r_owner  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= '0;
            r_err    <= '0;
            if (w_start) begin
                r_owner <= w_arb_idx;
                r_ptr   <= w_arb_idx;
                r_we    <= bus.we_i[w_arb_idx];
                r_addr  <= bus.addr_i[int'(w_arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= bus.wdata_i[int'(w_arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A matching ack in the timeout cycle wins, so w_timeout already excludes it.
            if (w_done) begin
                r_rvalid[r_owner] <= 1'b1;
                r_err[r_owner]    <= w_timeout;
                r_rdata           <= w_timeout ? ERR_DATA : (r_we ? '0 : bus.uart_rdata_i);
            end
        end
    end

    assign bus.gnt_o        = w_gnt;
    assign bus.rvalid_o     = r_rvalid;
    assign bus.err_o        = r_err;
    assign bus.rdata_o      = r_rdata;
    assign bus.uart_addr_o  = r_addr;
    assign bus.uart_wdata_o = r_wdata;
    assign bus.uart_rreq_o  = (r_state == BUSY) && !r_we;
    assign bus.uart_wreq_o  = (r_state == BUSY) && r_we;
    assign busy_o           = (r_state == BUSY);

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin by "last served", ack delay, timeout budget).
module tb_uart_port_arbiter;
    import uart_port_arbiter_pkg::*;

    localparam int                 T       = 8;
    localparam logic [31:0]        ERR_VAL = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // model state
    int          last_srv = 1;
    logic        m_we[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    bit          pend = 1'b0;
    logic [1:0]  pend_oh;
    bit          pend_err;
    logic [31:0] pend_data;

    uart_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    uart_port_arbiter #(
        .NUM_REQ        (2),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR_VAL)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus_if.slave),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after the one served last, in circular order.
    function automatic int rr_pick(input logic [1:0] m, input int last);
        for (int k = 1; k <= 2; k++) begin
            if (m[(last + k) % 2]) return (last + k) % 2;
        end
        return 0;
    endfunction

    task automatic check_completion();
        if (pend) begin
            check("rvalid", bus_if.rvalid_o, pend_oh);
            check("err", bus_if.err_o, pend_err ? pend_oh : 2'b00);
            check("rdata", bus_if.rdata_o, pend_data);
            check("req_drop", {bus_if.uart_rreq_o, bus_if.uart_wreq_o}, 2'b00);
            pend = 1'b0;
        end else begin
            check("rvalid_quiet", bus_if.rvalid_o, 2'b00);
        end
    endtask

    task automatic set_req_data(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        m_we[i]    = we;
        m_addr[i]  = addr;
        m_wdata[i] = wd;
        bus_if.we_i[i]               = we;
        bus_if.addr_i[i*32 +: 32]    = addr;
        bus_if.wdata_i[i*32 +: 32]   = wd;
    endtask

    // Called just after a rising edge with the arbiter idle; returns just after the edge that
    // starts the completion cycle (completion is checked by the next txn or idle_cycle).
    task automatic txn(input logic [1:0] mask, input int delay, input bit wrong, input bit hold,
                       input int force_we);
        int          win;
        logic [1:0]  oh;
        logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            if (mask[i]) begin
                set_req_data(i, (force_we < 0) ? 1'($urandom_range(0, 1)) : 1'(force_we),
                             $urandom, $urandom);
            end
        end
        bus_if.req_i = mask;
        @(negedge clk);
        check_completion();
        win = rr_pick(mask, last_srv);
        oh  = 2'b01 << win;
        check("gnt", bus_if.gnt_o, oh);
        check("busy_at_gnt", busy, 1'b0);
        last_srv = win;
        tick();
        bus_if.req_i = hold ? mask : 2'b00;
        rd = $urandom;
        for (int c = 0; c < T; c++) begin
            bus_if.uart_rack_i = 1'b0;
            bus_if.uart_wack_i = 1'b0;
            if (c == delay) begin
                bus_if.uart_wack_i  = m_we[win];
                bus_if.uart_rack_i  = !m_we[win];
                bus_if.uart_rdata_i = rd;
            end else if (wrong && c < delay) begin
                bus_if.uart_wack_i  = !m_we[win];
                bus_if.uart_rack_i  = m_we[win];
                bus_if.uart_rdata_i = $urandom;
            end
            @(negedge clk);
            check("rreq", bus_if.uart_rreq_o, !m_we[win]);
            check("wreq", bus_if.uart_wreq_o, m_we[win]);
            check("uart_addr", bus_if.uart_addr_o, m_addr[win]);
            if (m_we[win]) check("uart_wdata", bus_if.uart_wdata_o, m_wdata[win]);
            check("gnt_in_busy", bus_if.gnt_o, 2'b00);
            check("rvalid_in_busy", bus_if.rvalid_o, 2'b00);
            if (c == delay || c == T - 1) begin
                pend      = 1'b1;
                pend_oh   = oh;
                pend_err  = (c != delay);
                pend_data = pend_err ? ERR_VAL : (m_we[win] ? 32'h0 : rd);
                tick();
                break;
            end
            tick();
        end
        bus_if.uart_rack_i = 1'b0;
        bus_if.uart_wack_i = 1'b0;
    endtask

    task automatic idle_cycle();
        bus_if.req_i = 2'b00;
        @(negedge clk);
        check_completion();
        check("gnt_idle", bus_if.gnt_o, 2'b00);
        tick();
    endtask

    initial begin
        bus_if.req_i        = 2'b11;
        bus_if.we_i         = 2'b11;
        bus_if.addr_i       = '1;
        bus_if.wdata_i      = '1;
        bus_if.uart_rack_i  = 1'b0;
        bus_if.uart_wack_i  = 1'b0;
        bus_if.uart_rdata_i = '0;

        // reset state, with requests present
        repeat (2) tick();
        @(negedge clk);
        check("rst_gnt", bus_if.gnt_o, 2'b00);
        check("rst_rvalid", bus_if.rvalid_o, 2'b00);
        check("rst_err", bus_if.err_o, 2'b00);
        check("rst_rdata", bus_if.rdata_o, 32'h0);
        check("rst_uart_req", {bus_if.uart_rreq_o, bus_if.uart_wreq_o}, 2'b00);
        check("rst_uart_addr", bus_if.uart_addr_o, 32'h0);
        check("rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;

        // single read from requester 0, uart answers in the fourth busy cycle
        set_req_data(0, 1'b0, 32'h1000_0004, 32'h0);
        bus_if.req_i = 2'b01;
        @(negedge clk);
        check("t1_gnt", bus_if.gnt_o, 2'b01);
        last_srv = 0;
        tick();
        bus_if.req_i = 2'b00;
        @(negedge clk);
        check("t1_rreq", bus_if.uart_rreq_o, 1'b1);
        check("t1_addr", bus_if.uart_addr_o, 32'h1000_0004);
        repeat (3) tick();
        bus_if.uart_rack_i  = 1'b1;
        bus_if.uart_rdata_i = 32'h41;
        @(negedge clk);
        check("t1_rvalid_early", bus_if.rvalid_o, 2'b00);
        tick();
        bus_if.uart_rack_i = 1'b0;
        @(negedge clk);
        check("t1_rvalid", bus_if.rvalid_o, 2'b01);
        check("t1_rdata", bus_if.rdata_o, 32'h41);
        check("t1_err", bus_if.err_o, 2'b00);
        check("t1_rreq_drop", bus_if.uart_rreq_o, 1'b0);
        tick();

        // reset pulse while a write is in flight
        set_req_data(1, 1'b1, 32'h20, 32'h5A);
        bus_if.req_i = 2'b10;
        @(negedge clk);
        check("t5_gnt", bus_if.gnt_o, 2'b10);
        tick();
        bus_if.req_i = 2'b00;
        @(negedge clk);
        check("t5_wreq", bus_if.uart_wreq_o, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_uart_req", {bus_if.uart_rreq_o, bus_if.uart_wreq_o}, 2'b00);
        check("t5_rvalid", bus_if.rvalid_o, 2'b00);
        check("t5_busy", busy, 1'b0);
        last_srv = 1;
        tick();

        // both requesters hold req continuously: six writes alternate starting with requester 0
        for (int n = 0; n < 6; n++) txn(2'b11, n % 2, 1'b0, 1'b1, 1);
        idle_cycle();

        // write with no ack: timeout after T busy cycles
        txn(2'b01, 100, 1'b0, 1'b0, 1);
        idle_cycle();

        // read answered first with the wrong ack type
        txn(2'b10, 3, 1'b1, 1'b0, 0);
        idle_cycle();

        // matching ack exactly in the timeout cycle
        txn(2'b01, T - 1, 1'b0, 1'b0, 0);
        idle_cycle();
        txn(2'b10, T - 1, 1'b1, 1'b0, 1);
        idle_cycle();

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            txn(2'($urandom_range(1, 3)),
                ($urandom_range(0, 6) == 0) ? T + 3 : $urandom_range(0, 4),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
